// File: rtl/pipeline_pkg.sv
// Shared constants for the forward codeword pipeline Y = (3X+5)*2+7 and its inverse.
// Holds the offsets, the divisor, the stage count and the error-flag layout.
package pipeline_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int NUM_STAGES = 4;
  localparam int OFFSET_IN  = 7;
  localparam int OFFSET_MID = 5;
  localparam int DIVISOR    = 3;

  localparam int ERR_W      = 2;
  localparam int ERR_PARITY = 0;
  localparam int ERR_DIV    = 1;

  // Multiplicative inverse of 3 modulo 2^64; any low slice is the inverse modulo that width.
  localparam logic [63:0] DIV3_INV = 64'hAAAA_AAAA_AAAA_AAAB;

  typedef logic [ERR_W-1:0] err_t;

  function automatic int fwd_encode(input int x);
    return (x * DIVISOR + OFFSET_MID) * 2 + OFFSET_IN;
  endfunction

endpackage

// File: rtl/div3_exact.sv
// Combinational exact divide-by-3 of a signed value, flagging a nonzero remainder.
// Multiplies by the modular inverse of 3; only true multiples land in the small quotient window.
module div3_exact
  import pipeline_pkg::*;
#(
  parameter int N = 17
) (
  input  logic signed [N-1:0] e,
  output logic signed [N-1:0] quo,
  output logic                rem_nz
);

  localparam logic [N-1:0]        INV    = DIV3_INV[N-1:0];
  localparam longint              QLIM_L = ((longint'(1) << (N-1)) - 1) / 3;
  localparam logic signed [N-1:0] QLIM   = N'(QLIM_L);

  logic [N-1:0] prod;

  always_comb begin
    prod   = e * INV;
    quo    = $signed(prod);
    rem_nz = ($signed(prod) > QLIM) || ($signed(prod) < -QLIM);
  end

endmodule

// File: rtl/pipeline_inv.sv
// Four-stage inverse of Y = (3X+5)*2+7 with parity and divisibility error flags; latency 4.
// One global advance stalls every stage while the output is held; in_ready follows it directly.
module pipeline_inv
  import pipeline_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] Y,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] X,
  output logic [ERR_W-1:0]        err
);

  localparam int DW = WIDTH + 1;
  localparam logic signed [DW-1:0] OFS_IN  = DW'(OFFSET_IN);
  localparam logic signed [DW-1:0] OFS_MID = DW'(OFFSET_MID);

  logic                    advance;

  logic                    s1_vld_q, s1_vld_d;
  logic signed [DW-1:0]    s1_d_q,   s1_d_d;
  logic                    s1_par_q, s1_par_d;

  logic                    s2_vld_q, s2_vld_d;
  logic signed [DW-1:0]    s2_h_q,   s2_h_d;
  logic                    s2_par_q, s2_par_d;

  logic                    s3_vld_q, s3_vld_d;
  logic signed [DW-1:0]    s3_e_q,   s3_e_d;
  logic                    s3_par_q, s3_par_d;

  logic                    out_vld_q, out_vld_d;
  logic signed [WIDTH-1:0] x_q,       x_d;
  err_t                    err_q,     err_d;

  logic signed [DW-1:0]    quo;
  logic                    rem_nz;

  assign advance   = !out_vld_q | out_ready;
  assign in_ready  = advance;
  assign out_valid = out_vld_q;
  assign X         = x_q;
  assign err       = err_q;

  div3_exact #(.N(DW)) u_div3 (
    .e      (s3_e_q),
    .quo    (quo),
    .rem_nz (rem_nz)
  );

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_d_d    = s1_d_q;
    s1_par_d  = s1_par_q;
    s2_vld_d  = s2_vld_q;
    s2_h_d    = s2_h_q;
    s2_par_d  = s2_par_q;
    s3_vld_d  = s3_vld_q;
    s3_e_d    = s3_e_q;
    s3_par_d  = s3_par_q;
    out_vld_d = out_vld_q;
    x_d       = x_q;
    err_d     = err_q;

    if (advance) begin
      s1_vld_d = in_valid;
      if (in_valid) begin
        s1_d_d   = DW'(Y) - OFS_IN;
        s1_par_d = s1_d_d[0];
      end

      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_h_d   = s1_d_q >>> 1;
        s2_par_d = s1_par_q;
      end

      s3_vld_d = s2_vld_q;
      if (s2_vld_q) begin
        s3_e_d   = s2_h_q - OFS_MID;
        s3_par_d = s2_par_q;
      end

      out_vld_d = s3_vld_q;
      if (s3_vld_q) begin
        // A parity failure makes the divisibility result meaningless, so it masks err[1].
        err_d = '0;
        if (s3_par_q) begin
          err_d[ERR_PARITY] = 1'b1;
        end else if (rem_nz) begin
          err_d[ERR_DIV] = 1'b1;
        end
        x_d = (err_d == '0) ? quo[WIDTH-1:0] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_d_q    <= '0;
      s1_par_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_h_q    <= '0;
      s2_par_q  <= 1'b0;
      s3_vld_q  <= 1'b0;
      s3_e_q    <= '0;
      s3_par_q  <= 1'b0;
      out_vld_q <= 1'b0;
      x_q       <= '0;
      err_q     <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_d_q    <= s1_d_d;
      s1_par_q  <= s1_par_d;
      s2_vld_q  <= s2_vld_d;
      s2_h_q    <= s2_h_d;
      s2_par_q  <= s2_par_d;
      s3_vld_q  <= s3_vld_d;
      s3_e_q    <= s3_e_d;
      s3_par_q  <= s3_par_d;
      out_vld_q <= out_vld_d;
      x_q       <= x_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: doc/pipeline_inv.md
PIPELINE_INV -- requirements
Module: pipeline_inv

Interface
REQ-001 SHALL have parameter: WIDTH, 16, bit width of signed data input Y and output X.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  Y carries a sample this cycle.
REQ-005 SHALL have port: in_ready  output  1  block accepts a sample this cycle.
REQ-006 SHALL have port: Y  input  WIDTH  signed codeword from the forward pipeline (Y = (3X+5)*2+7).
REQ-007 SHALL have port: out_valid  output  1  X and err are valid.
REQ-008 SHALL have port: out_ready  input  1  downstream accepts the output this cycle.
REQ-009 SHALL have port: X  output  WIDTH  signed recovered value.
REQ-010 SHALL have port: err  output  2  bit0 = parity error ((Y-7) odd); bit1 = divisibility error ((Y-7)/2-5 not a multiple of 3).

Function
REQ-011 SHALL compute, in integer (non-wrapping) arithmetic: d = Y-7 (WIDTH+1 bits), h = d>>>1, e = h-5, X = e/3 (exact).
REQ-012 SHALL spread the computation over 4 registered stages: S1 d and parity check; S2 h; S3 e and mod-3 check; S4 X, err and out_valid.
REQ-013 SHALL have a latency of exactly 4 clk edges from an accepted input (in_valid & in_ready) to out_valid, when not stalled.
REQ-014 SHALL carry a valid bit per stage; a stage with its valid bit low holds its data unchanged.
REQ-015 SHALL use one global advance signal: advance = !out_valid | out_ready; all stages shift only when advance is 1.
REQ-016 SHALL drive in_ready = advance, combinationally.
REQ-017 SHALL hold X, err and out_valid stable while out_valid=1 and out_ready=0.
REQ-018 SHALL, when any err bit is set, drive X = 0 with out_valid=1; the sample is not dropped.
REQ-019 SHALL set err[1] only when err[0]=0.
REQ-020 SHALL ensure all intermediates fit without overflow for every WIDTH-bit Y (X within about +/-2^(WIDTH-1)/6); no saturation logic.
REQ-021 SHALL sustain one sample per cycle with back-to-back in_valid and out_ready held high.
REQ-022 SHALL preserve sample order with no loss or duplication under any out_ready pattern.
REQ-023 SHALL ignore Y when in_valid=0 or in_ready=0.

Reset
REQ-024 SHALL, on rst=1 at a clk edge, clear all stage valid bits, out_valid, X and err to 0.
REQ-025 SHALL give reset priority over advance; samples in flight during reset are discarded.
REQ-026 SHALL drive in_ready=1 in the first cycle after reset.

Structure
REQ-027 SHALL place WIDTH default, stage count (4), OFFSET_IN=7, OFFSET_MID=5, the divisor 3 and the err bit indices in shared package pipeline_pkg, also used by the forward pipeline.
REQ-028 SHALL implement the exact divide-by-3 with mod-3 check (input e, outputs quotient and remainder-nonzero flag) as the combinational sub-module div3_exact, instantiated in S3/S4.
REQ-029 SHALL not use a general-purpose divider or a multi-cycle divider.

Verification
REQ-030 SHALL verify: Y=23 in, out_ready=1 -> 4 cycles later out_valid=1, X=1, err=0.
REQ-031 SHALL verify: Y=-7 -> X=-4, err=0; Y=24 -> X=0, err=01; Y=25 -> X=0, err=10.
REQ-032 SHALL verify: 1000 random X in [-5000,5000] through the forward pipeline, then this block -> identical X stream, err=0, one sample per cycle.
REQ-033 SHALL verify: 3 back-to-back samples, then out_ready=0 for 5 cycles -> in_ready=0 while output stalled, X held, all 3 emitted in order after release.
REQ-034 SHALL verify: rst pulsed with 3 samples in flight -> out_valid=0 next cycle and no stale sample appears afterwards.
REQ-035 SHALL verify: Y=32767 and Y=-32768 -> correct X or err, with no overflow.
